// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit: decodes IR and sequences T0..T5 datapath strobes.
// Outputs are a Moore decode of the state register and IR.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        ZLowIn,
  output logic        ZLowOut,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rout,
  output logic        Rin,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        instr_done,
  output logic        illegal,
  output logic [15:0] instr_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] T0     = 3'd1;
  localparam logic [2:0] T1     = 3'd2;
  localparam logic [2:0] T2     = 3'd3;
  localparam logic [2:0] T3     = 3'd4;
  localparam logic [2:0] T4     = 3'd5;
  localparam logic [2:0] T5     = 3'd6;
  localparam logic [2:0] HALTED = 3'd7;

  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       stop_pending;
  logic [4:0] opcode;
  logic [4:0] op_minus2;
  logic       is_bin;
  logic       is_un;
  logic       is_nop;
  logic       is_halt;
  logic [3:0] bin_alu;
  logic [3:0] un_alu;
  logic [2:0] boundary;

  // Register fields are consumed by the datapath's own decoder, not here.
  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  assign opcode    = IR[31:27];
  assign op_minus2 = opcode - 5'd2;
  assign is_bin    = (opcode >= 5'd3) && (opcode <= 5'd10);
  assign is_un     = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_nop    = (opcode == OP_NOP);
  assign is_halt   = (opcode == OP_HALT);
  // Binary opcodes 00011..01010 map onto ALU codes 0001..1000 in order.
  assign bin_alu   = op_minus2[3:0];
  assign un_alu    = (opcode == OP_NEG) ? 4'b1001 : 4'b1010;
  assign boundary  = stop_pending ? IDLE : T0;

  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; ZLowIn = 1'b0;
    ZLowOut = 1'b0; PCin = 1'b0; Read = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rout = 1'b0; Rin = 1'b0;
    alu_op = 4'b0000;
    instr_done = 1'b0;
    illegal = 1'b0;
    run = (state != IDLE) && (state != HALTED);
    case (state)
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
      end
      T1: begin
        ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      T3: begin
        if (is_bin) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_un) begin
          Grb = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; alu_op = un_alu;
        end else if (is_nop || is_halt) begin
          instr_done = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      T4: begin
        if (is_bin) begin
          Grc = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; alu_op = bin_alu;
        end else begin
          ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
        end
      end
      T5: begin
        ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HALTED: if (start && !stop) state_nxt = T0;
      T0: state_nxt = T1;
      T1: state_nxt = T2;
      T2: state_nxt = T3;
      T3: begin
        if (is_bin || is_un) state_nxt = T4;
        else if (is_halt)    state_nxt = HALTED;
        else                 state_nxt = boundary;
      end
      T4: state_nxt = is_bin ? T5 : boundary;
      T5: state_nxt = boundary;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state        <= IDLE;
      stop_pending <= 1'b0;
      instr_count  <= 16'h0000;
    end else begin
      state <= state_nxt;
      if ((state_nxt == IDLE) || (state_nxt == HALTED))
        stop_pending <= 1'b0;
      else if (run && stop)
        stop_pending <= 1'b1;
      if (instr_done)
        instr_count <= instr_count + 16'h0001;
    end
  end

endmodule
